instr_fetch_unit: RTL and testbench

- Sequential instruction-fetch stage that sits directly upstream of the control FSM in the simple processor.
- Owns the program counter and drives the address into the combinational program ROM.
- Latches the returned code word into an instruction register and presents it to the FSM with a valid/ack handshake.
- Replaces the free-running address latch; adds jump and halt-stop behaviour.

---
 rtl/instr_fetch_unit.sv | 83 ++++++++
 tb/tb_instr_fetch_unit.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the program ROM, and holds
// the fetched word for the control FSM behind a valid/ack handshake.
module instr_fetch_unit #(
  parameter int          ADDR_W   = 5,
  parameter int          CODE_W   = 23,
  parameter logic  [3:0] HALT_OPC = 4'hF,
  parameter int          CNT_W    = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [CODE_W-1:0] code_in,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [CODE_W-1:0] instr_out,
  output logic              instr_valid,
  input  logic              instr_ack,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic              halted,
  output logic [CNT_W-1:0]  instr_count
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    VALID = 2'd1,
    HALT  = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] PC_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic              is_halt;

  // ROM address comes straight from the PC register: no path from ack/jump.
  assign rom_addr = pc;
  assign is_halt  = (code_in[CODE_W-1 -: 4] == HALT_OPC);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= FETCH;
      pc          <= '0;
      instr_out   <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      instr_count <= '0;
    end else begin
      unique case (state)
        FETCH: begin
          instr_out <= code_in;
          pc        <= pc + PC_ONE;
          if (is_halt) begin
            state  <= HALT;
            halted <= 1'b1;
          end else begin
            state       <= VALID;
            instr_valid <= 1'b1;
          end
        end
        VALID: begin
          if (instr_ack) begin
            if (instr_count != CNT_MAX)
              instr_count <= instr_count + CNT_ONE;
            if (jump_en)
              pc <= jump_addr;
            state       <= FETCH;
            instr_valid <= 1'b0;
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state       <= FETCH;
          instr_valid <= 1'b0;
          halted      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a behavioural ROM array.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_instr_fetch_unit;

  logic        clk;
  logic        resetn;
  logic [22:0] code_in;
  logic [4:0]  rom_addr;
  logic [22:0] instr_out;
  logic        instr_valid;
  logic        instr_ack;
  logic        jump_en;
  logic [4:0]  jump_addr;
  logic        halted;
  logic [7:0]  instr_count;

  logic [22:0] rom [32];
  int n_tests;
  int n_fail;

  assign code_in = rom[rom_addr];

  instr_fetch_unit dut (
    .clk         (clk),
    .resetn      (resetn),
    .code_in     (code_in),
    .rom_addr    (rom_addr),
    .instr_out   (instr_out),
    .instr_valid (instr_valid),
    .instr_ack   (instr_ack),
    .jump_en     (jump_en),
    .jump_addr   (jump_addr),
    .halted      (halted),
    .instr_count (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_rom();
    for (int i = 0; i < 32; i++) rom[i] = 23'(i + 'h100);
  endtask

  task automatic do_reset();
    instr_ack = 1'b0;
    jump_en   = 1'b0;
    jump_addr = '0;
    resetn    = 1'b0;
    tick();
    resetn    = 1'b1;
  endtask

  task automatic test_reset();
    fill_rom();
    rom[0] = 23'h000001;
    do_reset();
    n_tests++;
    if (instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_valid got %b exp 0", instr_valid);
    end
    n_tests++;
    if (instr_out !== 23'h0) begin
      n_fail++;
      $display("FAIL rst_out got %h exp 0", instr_out);
    end
    n_tests++;
    if (halted !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_halted got %b exp 0", halted);
    end
    n_tests++;
    if (instr_count !== 8'h0) begin
      n_fail++;
      $display("FAIL rst_count got %h exp 0", instr_count);
    end
    n_tests++;
    if (rom_addr !== 5'd0) begin
      n_fail++;
      $display("FAIL rst_addr got %0d exp 0", rom_addr);
    end
  endtask

  task automatic test_sequence();
    fill_rom();
    rom[0] = 23'h000001;
    rom[1] = 23'h000002;
    rom[2] = 23'h000003;
    do_reset();
    instr_ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_tests++;
      if (instr_valid !== 1'b1 || instr_out !== 23'(k + 1)) begin
        n_fail++;
        $display("FAIL seq_valid%0d got v=%b %h exp v=1 %h",
                 k, instr_valid, instr_out, 23'(k + 1));
      end
      n_tests++;
      if (rom_addr !== 5'(k + 1)) begin
        n_fail++;
        $display("FAIL seq_addr%0d got %0d exp %0d", k, rom_addr, k + 1);
      end
      tick();
      n_tests++;
      if (instr_valid !== 1'b0 || instr_count !== 8'(k + 1)) begin
        n_fail++;
        $display("FAIL seq_ack%0d got v=%b cnt=%0d exp v=0 cnt=%0d",
                 k, instr_valid, instr_count, k + 1);
      end
    end
    instr_ack = 1'b0;
  endtask

  task automatic test_stall();
    fill_rom();
    rom[0] = 23'h012345;
    do_reset();
    tick();
    for (int k = 0; k < 5; k++) begin
      tick();
      n_tests++;
      if (instr_out !== 23'h012345 || instr_valid !== 1'b1 ||
          rom_addr !== 5'd1 || instr_count !== 8'd0) begin
        n_fail++;
        $display("FAIL stall%0d got %h v=%b a=%0d c=%0d exp 012345 v=1 a=1 c=0",
                 k, instr_out, instr_valid, rom_addr, instr_count);
      end
    end
  endtask

  task automatic test_jump();
    fill_rom();
    rom[20] = 23'h02A2A2;
    do_reset();
    tick();
    instr_ack = 1'b1;
    tick();
    instr_ack = 1'b0;
    tick();
    n_tests++;
    if (instr_out !== 23'h000101 || rom_addr !== 5'd2) begin
      n_fail++;
      $display("FAIL jmp_pre got %h a=%0d exp 000101 a=2", instr_out, rom_addr);
    end
    instr_ack = 1'b1;
    jump_en   = 1'b1;
    jump_addr = 5'd20;
    tick();
    instr_ack = 1'b0;
    jump_en   = 1'b0;
    n_tests++;
    if (rom_addr !== 5'd20) begin
      n_fail++;
      $display("FAIL jmp_addr got %0d exp 20", rom_addr);
    end
    tick();
    n_tests++;
    if (instr_out !== 23'h02A2A2 || instr_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL jmp_out got %h v=%b exp 02a2a2 v=1", instr_out, instr_valid);
    end
    jump_en   = 1'b1;
    jump_addr = 5'd3;
    tick();
    tick();
    jump_en = 1'b0;
    n_tests++;
    if (rom_addr !== 5'd21 || instr_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL jmp_noack got a=%0d v=%b exp a=21 v=1", rom_addr, instr_valid);
    end
  endtask

  task automatic test_halt();
    fill_rom();
    rom[3] = 23'h780000;
    do_reset();
    instr_ack = 1'b1;
    repeat (6) tick();
    n_tests++;
    if (instr_count !== 8'd3 || rom_addr !== 5'd3) begin
      n_fail++;
      $display("FAIL halt_pre got c=%0d a=%0d exp c=3 a=3", instr_count, rom_addr);
    end
    tick();
    for (int k = 0; k < 10; k++) begin
      instr_ack = k[0];
      n_tests++;
      if (halted !== 1'b1 || instr_valid !== 1'b0 || rom_addr !== 5'd4 ||
          instr_out !== 23'h780000 || instr_count !== 8'd3) begin
        n_fail++;
        $display("FAIL halt%0d got h=%b v=%b a=%0d o=%h c=%0d exp h=1 v=0 a=4 o=780000 c=3",
                 k, halted, instr_valid, rom_addr, instr_out, instr_count);
      end
      tick();
    end
    instr_ack = 1'b0;
  endtask

  task automatic test_wrap();
    fill_rom();
    rom[0]  = 23'h00ABCD;
    rom[31] = 23'h000031;
    do_reset();
    tick();
    instr_ack = 1'b1;
    jump_en   = 1'b1;
    jump_addr = 5'd31;
    tick();
    instr_ack = 1'b0;
    jump_en   = 1'b0;
    n_tests++;
    if (rom_addr !== 5'd31) begin
      n_fail++;
      $display("FAIL wrap_jmp got %0d exp 31", rom_addr);
    end
    tick();
    n_tests++;
    if (instr_out !== 23'h000031 || rom_addr !== 5'd0) begin
      n_fail++;
      $display("FAIL wrap_pc got %h a=%0d exp 000031 a=0", instr_out, rom_addr);
    end
    instr_ack = 1'b1;
    tick();
    instr_ack = 1'b0;
    tick();
    n_tests++;
    if (instr_out !== 23'h00ABCD || rom_addr !== 5'd1) begin
      n_fail++;
      $display("FAIL wrap_rom0 got %h a=%0d exp 00abcd a=1", instr_out, rom_addr);
    end
  endtask

  task automatic test_saturate();
    fill_rom();
    do_reset();
    instr_ack = 1'b1;
    repeat (508) tick();
    n_tests++;
    if (instr_count !== 8'hFE) begin
      n_fail++;
      $display("FAIL sat_fe got %h exp fe", instr_count);
    end
    repeat (4) tick();
    n_tests++;
    if (instr_count !== 8'hFF) begin
      n_fail++;
      $display("FAIL sat_ff got %h exp ff", instr_count);
    end
    repeat (2) tick();
    n_tests++;
    if (instr_count !== 8'hFF) begin
      n_fail++;
      $display("FAIL sat_hold got %h exp ff", instr_count);
    end
    instr_ack = 1'b0;
  endtask

  task automatic test_reset_mid();
    fill_rom();
    do_reset();
    tick();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    n_tests++;
    if (instr_valid !== 1'b0 || instr_out !== 23'h0 || rom_addr !== 5'd0 ||
        halted !== 1'b0 || instr_count !== 8'd0) begin
      n_fail++;
      $display("FAIL rstv got v=%b o=%h a=%0d h=%b c=%0d exp all 0",
               instr_valid, instr_out, rom_addr, halted, instr_count);
    end
    tick();
    n_tests++;
    if (instr_out !== 23'h000100 || instr_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rstv_restart got %h v=%b exp 000100 v=1", instr_out, instr_valid);
    end
    rom[0] = 23'h780000;
    do_reset();
    tick();
    n_tests++;
    if (halted !== 1'b1) begin
      n_fail++;
      $display("FAIL rsth_pre got %b exp 1", halted);
    end
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    n_tests++;
    if (halted !== 1'b0 || instr_out !== 23'h0 || rom_addr !== 5'd0 ||
        instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rsth got h=%b o=%h a=%0d v=%b exp all 0",
               halted, instr_out, rom_addr, instr_valid);
    end
    rom[0] = 23'h000100;
    tick();
    n_tests++;
    if (instr_out !== 23'h000100 || instr_valid !== 1'b1 || halted !== 1'b0) begin
      n_fail++;
      $display("FAIL rsth_restart got %h v=%b h=%b exp 000100 v=1 h=0",
               instr_out, instr_valid, halted);
    end
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    resetn    = 1'b0;
    instr_ack = 1'b0;
    jump_en   = 1'b0;
    jump_addr = '0;
    fill_rom();
    #1;
    test_reset();
    test_sequence();
    test_stall();
    test_jump();
    test_halt();
    test_wrap();
    test_saturate();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
